// File: rtl/div_unit_pkg.sv
// Shared definitions for the RV32M iterative divider: operand width, op encoding,
// FSM state type and small decode helpers.
package div_unit_pkg;

    localparam int XLEN = 32;

    localparam logic [1:0] OP_DIV  = 2'd0;
    localparam logic [1:0] OP_DIVU = 2'd1;
    localparam logic [1:0] OP_REM  = 2'd2;
    localparam logic [1:0] OP_REMU = 2'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_e;

    function automatic logic is_signed_op(input logic [1:0] op);
        return (op == OP_DIV) || (op == OP_REM);
    endfunction

    function automatic logic is_rem_op(input logic [1:0] op);
        return (op == OP_REM) || (op == OP_REMU);
    endfunction

    // Two's-complement magnitude; the most negative value maps onto itself and is read as unsigned.
    function automatic logic [XLEN-1:0] magnitude(input logic [XLEN-1:0] x, input logic neg);
        return neg ? (~x + {{(XLEN-1){1'b0}}, 1'b1}) : x;
    endfunction

endpackage

// File: rtl/div_unit_if.sv
// Request/response handshake bundle between the execute stage and the divider.
interface div_unit_if;
    import div_unit_pkg::*;

    logic            in_valid;
    logic            in_ready;
    logic [1:0]      op;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic            flush;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic            busy;

    modport master (
        output in_valid, op, a, b, flush, out_ready,
        input  in_ready, out_valid, result, busy
    );

    modport slave (
        input  in_valid, op, a, b, flush, out_ready,
        output in_ready, out_valid, result, busy
    );

endinterface

// File: rtl/div_unit_adder.sv
// The execute-stage 32-bit adder with carry in/out, shared by trial subtract and sign fix-up.
module div_unit_adder
    import div_unit_pkg::*;
(
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            cin,
    output logic [XLEN-1:0] sum,
    output logic            cout
);

    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{XLEN{1'b0}}, cin};

endmodule

// File: rtl/div_unit.sv
// Radix-2 restoring divider for DIV/DIVU/REM/REMU: 32 trial-subtract iterations,
// one sign fix-up cycle, then the result is held until the consumer takes it.
module div_unit
    import div_unit_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    div_unit_if.slave  bus
);

    state_e          state_r;
    logic [4:0]      cnt_r;
    logic [XLEN-1:0] rem_r;
    logic [XLEN-1:0] quo_r;
    logic [XLEN-1:0] div_r;
    logic [XLEN-1:0] result_r;
    logic            is_rem_r;
    logic            neg_q_r;
    logic            neg_r_r;
    logic            in_ready_r;
    logic            out_valid_r;
    logic            busy_r;

    logic [XLEN-1:0] rem_shift_s;
    logic [XLEN-1:0] fix_src_s;
    logic [XLEN-1:0] add_a_s;
    logic [XLEN-1:0] add_b_s;
    logic [XLEN-1:0] add_sum_s;
    logic [XLEN-1:0] special_res_s;
    logic            add_cin_s;
    logic            add_cout_s;
    logic            q_bit_s;
    logic            fix_neg_s;
    logic            accept_s;
    logic            signed_s;
    logic            sign_a_s;
    logic            sign_b_s;
    logic            div0_s;
    logic            ovf_s;

    div_unit_adder u_adder (
        .a    (add_a_s),
        .b    (add_b_s),
        .cin  (add_cin_s),
        .sum  (add_sum_s),
        .cout (add_cout_s)
    );

    // Adder operand mux: negation (~x + 1) in FIX, trial subtract (rem - divisor) otherwise.
    always_comb begin
        rem_shift_s = {rem_r[XLEN-2:0], quo_r[XLEN-1]};
        fix_src_s   = is_rem_r ? rem_r : quo_r;
        fix_neg_s   = is_rem_r ? neg_r_r : neg_q_r;
        if (state_r == FIX) begin
            add_a_s   = ~fix_src_s;
            add_b_s   = {XLEN{1'b0}};
            add_cin_s = 1'b1;
        end else begin
            add_a_s   = rem_shift_s;
            add_b_s   = ~div_r;
            add_cin_s = 1'b1;
        end
        // A bit shifted out of rem means rem_shifted exceeds any 32-bit divisor.
        q_bit_s = rem_r[XLEN-1] | add_cout_s;
    end

    // Request decode: sign flags and the two cases resolved without iterating.
    always_comb begin
        accept_s = bus.in_valid && in_ready_r;
        signed_s = is_signed_op(bus.op);
        sign_a_s = signed_s & bus.a[XLEN-1];
        sign_b_s = signed_s & bus.b[XLEN-1];
        div0_s   = (bus.b == {XLEN{1'b0}});
        ovf_s    = signed_s && (bus.a == {1'b1, {(XLEN-1){1'b0}}}) && (bus.b == {XLEN{1'b1}});
        if (div0_s) begin
            special_res_s = is_rem_op(bus.op) ? bus.a : {XLEN{1'b1}};
        end else if (ovf_s) begin
            special_res_s = is_rem_op(bus.op) ? {XLEN{1'b0}} : {1'b1, {(XLEN-1){1'b0}}};
        end else begin
            special_res_s = {XLEN{1'b0}};
        end
    end

    // Control FSM with datapath registers and registered handshake outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            cnt_r       <= 5'd0;
            rem_r       <= {XLEN{1'b0}};
            quo_r       <= {XLEN{1'b0}};
            div_r       <= {XLEN{1'b0}};
            result_r    <= {XLEN{1'b0}};
            is_rem_r    <= 1'b0;
            neg_q_r     <= 1'b0;
            neg_r_r     <= 1'b0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        is_rem_r   <= is_rem_op(bus.op);
                        neg_q_r    <= sign_a_s ^ sign_b_s;
                        neg_r_r    <= sign_a_s;
                        quo_r      <= magnitude(bus.a, sign_a_s);
                        div_r      <= magnitude(bus.b, sign_b_s);
                        rem_r      <= {XLEN{1'b0}};
                        cnt_r      <= 5'd0;
                        in_ready_r <= 1'b0;
                        busy_r     <= 1'b1;
                        if (div0_s || ovf_s) begin
                            result_r <= special_res_s;
                            state_r  <= DONE;
                        end else begin
                            state_r  <= CALC;
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                CALC: begin
                    if (bus.flush) begin
                        state_r     <= IDLE;
                        cnt_r       <= 5'd0;
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        busy_r      <= 1'b0;
                    end else begin
                        rem_r <= q_bit_s ? add_sum_s : rem_shift_s;
                        quo_r <= {quo_r[XLEN-2:0], q_bit_s};
                        if (cnt_r == 5'd31) begin
                            cnt_r   <= 5'd0;
                            state_r <= FIX;
                        end else begin
                            cnt_r   <= cnt_r + 5'd1;
                        end
                    end
                end
                FIX: begin
                    if (bus.flush) begin
                        state_r     <= IDLE;
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        busy_r      <= 1'b0;
                    end else begin
                        result_r <= fix_neg_s ? add_sum_s : fix_src_s;
                        state_r  <= DONE;
                    end
                end
                DONE: begin
                    if (bus.flush) begin
                        state_r     <= IDLE;
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        busy_r      <= 1'b0;
                    end else if (out_valid_r && bus.out_ready) begin
                        state_r     <= IDLE;
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        busy_r      <= 1'b0;
                    end else begin
                        out_valid_r <= 1'b1;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    cnt_r       <= 5'd0;
                    out_valid_r <= 1'b0;
                    in_ready_r  <= 1'b1;
                    busy_r      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.result    = result_r;
    assign bus.busy      = busy_r;

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: directed operations push expected result and latency,
// an independent monitor compares at every result handoff.
module tb_div_unit;
    import div_unit_pkg::*;

    typedef struct {
        logic [31:0] res;
        int          lat;
        int          t;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    logic prev_v = 1'b0;
    exp_t sb[$];

    div_unit_if bus();

    div_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        failures++;
        $display("FAIL %s timeout", name);
    endtask

    // Monitor: latency on out_valid rise, result on each handoff.
    always begin
        exp_t e;
        @(negedge clk);
        #1;
        if (!rst) begin
            if (bus.out_valid && !prev_v) begin
                if (sb.size() == 0) check("unexpected_valid", 32'(bus.out_valid), 32'd0);
                else check("latency", 32'(cyc - sb[0].t), 32'(sb[0].lat));
            end
            if (bus.out_valid && bus.out_ready && sb.size() > 0) begin
                e = sb.pop_front();
                check("result", bus.result, e.res);
            end
            prev_v = bus.out_valid;
        end else begin
            prev_v = 1'b0;
        end
    end

    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic push, input logic [31:0] res, input int lat);
        exp_t e;
        int   n;
        n = 0;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.op = op;
        bus.a = a;
        bus.b = b;
        while (!bus.in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) timeout("accept");
        else if (push) begin
            e.res = res;
            e.lat = lat;
            e.t = cyc + 1;
            sb.push_back(e);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (!(bus.in_ready && !bus.out_valid) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) timeout("idle");
    endtask

    initial begin
        int n;
        bus.in_valid = 1'b0;
        bus.op = OP_DIV;
        bus.a = 32'd0;
        bus.b = 32'd0;
        bus.flush = 1'b0;
        bus.out_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_result", bus.result, 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        rst = 1'b0;

        issue(OP_DIVU, 32'd100, 32'd7, 1'b1, 32'd14, 34);          wait_idle();
        issue(OP_REMU, 32'd100, 32'd7, 1'b1, 32'd2, 34);           wait_idle();
        issue(OP_DIV, 32'hFFFFFFF9, 32'd2, 1'b1, 32'hFFFFFFFD, 34); wait_idle();
        issue(OP_REM, 32'hFFFFFFF9, 32'd2, 1'b1, 32'hFFFFFFFF, 34); wait_idle();
        issue(OP_REM, 32'd7, 32'hFFFFFFFE, 1'b1, 32'd1, 34);        wait_idle();
        issue(OP_DIVU, 32'd5, 32'd0, 1'b1, 32'hFFFFFFFF, 1);        wait_idle();
        issue(OP_REM, 32'd5, 32'd0, 1'b1, 32'd5, 1);                wait_idle();
        issue(OP_DIV, 32'h80000000, 32'hFFFFFFFF, 1'b1, 32'h80000000, 1); wait_idle();
        issue(OP_REM, 32'h80000000, 32'hFFFFFFFF, 1'b1, 32'd0, 1);  wait_idle();

        // Back-pressure: result held, new requests ignored.
        bus.out_ready = 1'b0;
        issue(OP_REMU, 32'd100, 32'd7, 1'b1, 32'd2, 34);
        n = 0;
        while (!bus.out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) timeout("bp_valid");
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            bus.in_valid = 1'b1;
            bus.op = OP_DIVU;
            bus.a = 32'd9;
            bus.b = 32'd3;
            check("bp_result", bus.result, 32'd2);
            check("bp_in_ready", 32'(bus.in_ready), 32'd0);
            check("bp_out_valid", 32'(bus.out_valid), 32'd1);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("bp_release_in_ready", 32'(bus.in_ready), 32'd1);
        check("bp_release_out_valid", 32'(bus.out_valid), 32'd0);

        // Async reset mid-iteration.
        issue(OP_DIVU, 32'hFFFFFFFF, 32'd3, 1'b0, 32'd0, 0);
        repeat (15) @(negedge clk);
        rst = 1'b1;
        #1;
        check("arst_out_valid", 32'(bus.out_valid), 32'd0);
        check("arst_in_ready", 32'(bus.in_ready), 32'd1);
        check("arst_busy", 32'(bus.busy), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Flush mid-iteration: no result may appear afterwards.
        issue(OP_DIVU, 32'hFFFFFFFF, 32'd3, 1'b0, 32'd0, 0);
        repeat (14) @(negedge clk);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        check("flush_in_ready", 32'(bus.in_ready), 32'd1);
        check("flush_busy", 32'(bus.busy), 32'd0);
        check("flush_out_valid", 32'(bus.out_valid), 32'd0);
        repeat (40) @(negedge clk);

        issue(OP_DIVU, 32'hFFFFFFFF, 32'd3, 1'b1, 32'h55555555, 34); wait_idle();
        repeat (3) @(negedge clk);
        check("sb_empty", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Iterative radix-2 restoring divider for the RV32M DIV/DIVU/REM/REMU instructions.
- Sits in the execute stage next to the ALU and uses the existing 32-bit Adder as its trial-subtract datapath.
- Accepts one operation via a valid/ready handshake and returns a 32-bit result, also via valid/ready.

Parameters:
- XLEN, 32, operand/result width; only 32 is supported, because the Adder instance is 32-bit.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  request valid
- in_ready  out  1  unit can accept; high only in IDLE
- op  in  2  0=DIV, 1=DIVU, 2=REM, 3=REMU
- a  in  XLEN  dividend (rs1)
- b  in  XLEN  divisor (rs2)
- flush  in  1  abort the in-flight operation (pipeline kill)
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts the result
- result  out  XLEN  quotient (DIV/DIVU) or remainder (REM/REMU)
- busy  out  1  high in every state except IDLE

Behaviour:
- Reset (async, rst=1): state=IDLE, in_ready=1, out_valid=0, result=0, busy=0, iteration counter=0, all internal registers=0.
- Accept: an operation is accepted on the rising edge where in_valid && in_ready. At that edge the unit latches op, the sign flags, |a| and |b|.
  - Absolute values are taken only for DIV/REM.
  - |-2^31| stays 0x80000000 and is treated as unsigned.
- States:
  - IDLE -> CALC on a normal accept.
  - IDLE -> DONE on a special-case accept.
  - CALC -> FIX when the counter reaches 31 (32 iterations).
  - FIX -> DONE.
  - DONE -> IDLE when out_ready=1.
- CALC iteration (one per cycle):
  - {rem,quo} shifts left by 1.
  - Trial subtract: Adder(a=rem_shifted, b=~divisor, cin=1).
  - Quotient bit q = shifted-out rem MSB | cout.
  - If q=1, rem takes the Adder sum; otherwise rem_shifted is kept.
  - The counter increments and wraps only through the FIX exit.
- FIX: applies signs.
  - Quotient is negated if sign(a)!=sign(b) (signed ops only).
  - Remainder is negated if sign(a)=1 (signed ops only).
  - Negation reuses the Adder (~x + 1) and is registered into result.
- Latency: normal ops raise out_valid after edge T+34, where T is the accept edge. That is 32 CALC cycles, 1 FIX cycle and the DONE entry.
- Special cases (decided at accept, result loaded directly, out_valid after edge T+1):
  - b==0: quotient=0xFFFFFFFF; remainder=a.
  - DIV/REM with a=0x80000000, b=0xFFFFFFFF: quotient=0x80000000, remainder=0.
- Output handshake:
  - out_valid and result are held stable until out_ready.
  - On the out_valid && out_ready edge, out_valid drops and in_ready rises on the same edge.
  - A new request is never accepted in the same cycle as a result handoff.
- flush:
  - Forces IDLE on the next edge from CALC, FIX or DONE, and out_valid=0.
  - flush in IDLE is ignored.
  - flush has priority over out_ready and over counter completion.
- in_valid during busy is ignored; a/b/op changes during busy have no effect.
- An async rst mid-operation returns the unit to the reset values immediately, with no residual output.

Decomposition:
- Shared package:
  - op encoding constants (OP_DIV, OP_DIVU, OP_REM, OP_REMU)
  - the state enum (IDLE, CALC, FIX, DONE)
  - XLEN
- Sub-module: the existing Adder, instantiated once and muxed between trial subtract and FIX negation.
- Everything else (FSM, counter, shift registers) is in div_unit.

Test Plan:
- DIVU a=100, b=7 -> result=14, out_valid exactly 34 cycles after accept; REMU with the same operands -> 2.
- DIV a=-7 (0xFFFFFFF9), b=2 -> 0xFFFFFFFD (-3); REM with the same operands -> 0xFFFFFFFF (-1); REM a=7, b=-2 -> 1.
- DIVU a=5, b=0 -> 0xFFFFFFFF; REM a=5, b=0 -> 5; both assert out_valid 1 cycle after accept.
- DIV a=0x80000000, b=0xFFFFFFFF -> 0x80000000; REM with the same operands -> 0; 1-cycle latency.
- Back-pressure: hold out_ready=0 for 10 cycles after out_valid -> result stable, in_ready=0, a new in_valid is ignored; raise out_ready -> next cycle in_ready=1.
- Robustness: assert rst at iteration 15 of DIVU 0xFFFFFFFF/3 -> out_valid=0 and in_ready=1 immediately; flush at iteration 15 -> IDLE next edge, no out_valid. A following DIVU 0xFFFFFFFF/3 -> 0x55555555.
